bloom_filter_unit: RTL and testbench
====================================

BLOOM_FILTER_UNIT -- requirements
Module: bloom_filter_unit

Interface
REQ-001 SHALL have parameter K_HASH, default 3, meaning number of hash probes per insert/check (legal 1..4).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  request offered.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_op  input  2  00 insert, 01 check, 10 clear, 11 reserved.
REQ-007 SHALL have port req_data  input  32  key (RS1 operand).
REQ-008 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-009 SHALL have port rsp_match  output  1  check result; 0 for non-check responses.
REQ-010 SHALL have port rsp_err  output  1  reserved-op response flag.
REQ-011 SHALL have port busy  output  1  state != IDLE.
REQ-012 SHALL have port insert_count  output  16  inserts since last clear/reset, saturating.

Function
REQ-013 SHALL hold a 256-bit filter array, addressed by 8-bit index.
REQ-014 SHALL compute hash j (0..K_HASH-1) as: x = req_data XOR rotl(req_data, 5+6j); h_j = x[7:0]^x[15:8]^x[23:16]^x[31:24].
REQ-015 SHALL register req_op and req_data on accept (req_valid && req_ready); later input changes have no effect.
REQ-016 SHALL implement FSM states IDLE, HASH, CLEAR, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL transition IDLE->HASH on accepted insert/check, IDLE->CLEAR on accepted clear, IDLE->RESP on accepted reserved op.
REQ-018 SHALL in HASH process exactly one probe per cycle (j = 0,1,...), move to RESP after probe K_HASH-1; no early exit.
REQ-019 SHALL for insert set bit h_j each HASH cycle; for check AND bit h_j into a match accumulator initialised to 1 at accept.
REQ-020 SHALL make check results reflect only completed prior operations (no overlap possible because ready=0 while busy).
REQ-021 SHALL in CLEAR zero 32-bit word w (w = 0..7) per cycle, 8 cycles, then RESP.
REQ-022 SHALL in RESP assert rsp_valid for exactly one cycle, then return to IDLE; no rsp backpressure.
REQ-023 SHALL give latency accept(T) -> rsp_valid at T+K_HASH+1 for insert/check, T+9 for clear, T+1 for reserved.
REQ-024 SHALL drive rsp_match = accumulator only for check responses, rsp_err = 1 only for reserved-op responses, both 0 otherwise.
REQ-025 SHALL increment insert_count at insert RESP, saturating at 0xFFFF; clear sets it to 0 at clear RESP.
REQ-026 SHALL treat duplicate indices within one key as harmless (bit stays set; count still +1).
REQ-027 SHALL ignore req_valid while req_ready = 0 (no queuing).

Reset
REQ-028 SHALL on rst, asynchronously: array all 0, state IDLE, probe/word counters 0, insert_count 0, rsp_valid/rsp_match/rsp_err 0, busy 0, req_ready 1 once rst deasserts.
REQ-029 SHALL abort any in-flight operation on rst with no response issued afterward.

Verification
REQ-030 SHALL cover: after reset, check 0x00000000 -> rsp_valid at T+4, rsp_match 0, insert_count 0.
REQ-031 SHALL cover: insert 0x00000000 (all h_j = 0) then check 0x00000000 -> rsp_match 1, insert_count 1, only array bit 0 set.
REQ-032 SHALL cover: insert 0xDEADBEEF, clear, check 0xDEADBEEF -> clear rsp at T+9, then rsp_match 0, insert_count 0.
REQ-033 SHALL cover: req_op 11 -> rsp_valid at T+1 with rsp_err 1, array and insert_count unchanged; req_valid held during busy accepted only on return to IDLE.
REQ-034 SHALL cover: rst asserted on second HASH cycle of an insert -> no rsp_valid, subsequent check of same key returns 0.
REQ-035 SHALL cover: 65536+2 inserts -> insert_count saturates at 0xFFFF.

Source files
------------

// File: rtl/bloom_filter_unit.sv
// rtl/bloom_filter_unit.sv - 256-bit Bloom filter with multi-cycle insert/check/clear
module bloom_filter_unit #(
  parameter int K_HASH = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic        rsp_match,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] insert_count
);

  typedef enum logic [1:0] {IDLE, HASH, CLEAR, RESP} state_t;

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_CHECK  = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;
  localparam logic [1:0] LAST_PROBE = 2'(K_HASH - 1);

  state_t        state, state_nxt;
  logic [255:0]  filter;
  logic [1:0]    op_q;
  logic [31:0]   key_q;
  logic [1:0]    probe;
  logic [2:0]    word;
  logic          match_acc;
  logic [7:0]    cur_idx;

  // Probe j: fold (key ^ rotl(key, 5+6j)) down to one byte.
  function automatic logic [7:0] hash_idx(input logic [31:0] key, input logic [1:0] j);
    logic [4:0]  sh;
    logic [31:0] x;
    sh = 5'd5 + 5'd6 * {3'b000, j};
    x  = key ^ ((key << sh) | (key >> (6'd32 - {1'b0, sh})));
    return x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
  endfunction

  assign cur_idx = hash_idx(key_q, probe);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_INSERT, OP_CHECK: state_nxt = HASH;
            OP_CLEAR:            state_nxt = CLEAR;
            default:             state_nxt = RESP;
          endcase
        end
      end
      HASH:    if (probe == LAST_PROBE) state_nxt = RESP;
      CLEAR:   if (word == 3'd7) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_match = (state == RESP) && (op_q == OP_CHECK) && match_acc;
  assign rsp_err   = (state == RESP) && (op_q == OP_RSVD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      filter       <= '0;
      op_q         <= OP_INSERT;
      key_q        <= '0;
      probe        <= '0;
      word         <= '0;
      match_acc    <= 1'b0;
      insert_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            key_q     <= req_data;
            probe     <= '0;
            word      <= '0;
            match_acc <= 1'b1;
          end
        end
        HASH: begin
          if (op_q == OP_INSERT) filter[cur_idx] <= 1'b1;
          else                   match_acc <= match_acc & filter[cur_idx];
          probe <= probe + 2'd1;
        end
        CLEAR: begin
          filter[{word, 5'b00000} +: 32] <= '0;
          word <= word + 3'd1;
        end
        RESP: begin
          if (op_q == OP_INSERT && insert_count != 16'hFFFF)
            insert_count <= insert_count + 16'd1;
          else if (op_q == OP_CLEAR)
            insert_count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bloom_filter_unit.sv
// tb/tb_bloom_filter_unit.sv - randomized bench for bloom_filter_unit against a set-of-bits model
module tb_bloom_filter_unit;

  localparam int K = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_data = 32'h0;
  logic        rsp_valid, rsp_match, rsp_err, busy;
  logic [15:0] insert_count;

  int checks = 0;
  int errors = 0;

  bit          model_bits [256];
  int          model_count = 0;
  logic [31:0] pool [8];

  bloom_filter_unit #(.K_HASH(K)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_match(rsp_match), .rsp_err(rsp_err),
    .busy(busy), .insert_count(insert_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] ref_hash(input logic [31:0] d, input int j);
    logic [31:0] r;
    logic [7:0]  h;
    int s;
    s = 5 + 6 * j;
    for (int i = 0; i < 32; i++) r[(i + s) % 32] = d[i];
    r = d ^ r;
    h = 8'h00;
    for (int b = 0; b < 4; b++) h = h ^ r[8*b +: 8];
    return h;
  endfunction

  function automatic logic [255:0] model_vec();
    logic [255:0] v;
    for (int i = 0; i < 256; i++) v[i] = model_bits[i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) model_bits[i] = 1'b0;
    model_count = 0;
  endfunction

  task automatic do_req(input logic [1:0] op, input logic [31:0] key, input string tag);
    int  lat;
    bit  seen;
    bit  exp_match;
    lat = (op == 2'b10) ? 9 : (op == 2'b11) ? 1 : K + 1;
    exp_match = 1'b0;
    if (op == 2'b01) begin
      exp_match = 1'b1;
      for (int j = 0; j < K; j++) if (!model_bits[ref_hash(key, j)]) exp_match = 1'b0;
    end
    @(negedge clk);
    check({tag, " ready"}, 256'(req_ready), 256'(1));
    req_valid = 1'b1;
    req_op    = op;
    req_data  = key;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = $urandom;
    req_op    = 2'($urandom_range(0, 3));
    seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        check({tag, " latency"}, 256'(n), 256'(lat));
        check({tag, " match"}, 256'(rsp_match), 256'(exp_match));
        check({tag, " err"}, 256'(rsp_err), 256'(op == 2'b11));
      end
    end
    if (!seen) check({tag, " rsp timeout"}, 256'(0), 256'(1));
    case (op)
      2'b00: begin
        for (int j = 0; j < K; j++) model_bits[ref_hash(key, j)] = 1'b1;
        if (model_count < 65535) model_count++;
      end
      2'b10: model_reset();
      default: ;
    endcase
    @(negedge clk);
    check({tag, " rsp pulse"}, 256'(rsp_valid), 256'(0));
    check({tag, " count"}, 256'(insert_count), 256'(model_count));
    check({tag, " array"}, dut.filter, model_vec());
  endtask

  initial begin
    int  r;
    bit  stray;
    logic [31:0] key;
    model_reset();
    for (int i = 0; i < 8; i++) pool[i] = $urandom;
    pool[0] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset ready", 256'(req_ready), 256'(1));
    check("reset busy", 256'(busy), 256'(0));
    check("reset rsp_valid", 256'(rsp_valid), 256'(0));
    check("reset count", 256'(insert_count), 256'(0));

    do_req(2'b01, 32'h0, "empty check zero");
    do_req(2'b00, 32'h0, "insert zero");
    check("zero key only bit0", dut.filter, 256'(1));
    do_req(2'b01, 32'h0, "check zero");

    do_req(2'b00, 32'hDEADBEEF, "insert deadbeef");
    do_req(2'b10, 32'h0, "clear");
    do_req(2'b01, 32'hDEADBEEF, "check after clear");

    do_req(2'b00, pool[1], "insert p1");
    do_req(2'b11, 32'h12345678, "reserved");

    // Request held through busy is taken only once IDLE returns.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_data = 32'h0;
    @(posedge clk);
    @(negedge clk);
    check("held n1 rsp", 256'(rsp_valid), 256'(1));
    check("held n1 ready", 256'(req_ready), 256'(0));
    @(negedge clk);
    check("held n2 rsp", 256'(rsp_valid), 256'(0));
    check("held n2 ready", 256'(req_ready), 256'(1));
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("held n3 rsp", 256'(rsp_valid), 256'(1));
    check("held n3 err", 256'(rsp_err), 256'(1));
    @(negedge clk);
    check("held n4 idle", 256'(busy), 256'(0));
    check("held array", dut.filter, model_vec());

    // Reset on the second HASH cycle of an insert.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_data = pool[2];
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async rst busy", 256'(busy), 256'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) stray = 1'b1;
    end
    check("no rsp after rst", 256'(stray), 256'(0));
    do_req(2'b01, pool[2], "check after rst");

    for (int t = 0; t < 60; t++) begin
      r   = $urandom_range(0, 99);
      key = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 7)];
      if (r < 40)      do_req(2'b00, key, "rand insert");
      else if (r < 85) do_req(2'b01, key, "rand check");
      else if (r < 92) do_req(2'b10, key, "rand clear");
      else             do_req(2'b11, key, "rand rsvd");
    end

    // Jump the counter near its ceiling rather than issuing 65536 inserts.
    @(negedge clk);
    force dut.insert_count = 16'hFFFD;
    #1 release dut.insert_count;
    model_count = 65533;
    for (int i = 0; i < 4; i++) do_req(2'b00, pool[i], "saturate insert");
    check("saturated", 256'(insert_count), 256'(16'hFFFF));
    do_req(2'b10, 32'h0, "clear after sat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
